// File: rtl/firebird7_in_gate1_tessent_tdr_w3_ctl_pkg.sv
// Shared types and helpers for the gate1 IJTAG test data registers.
// Holds the TDR operation decode used by this block and its sibling TDRs.
package firebird7_in_gate1_tdr_pkg;

  localparam int unsigned TDR_DATA_WIDTH = 3;
  localparam int unsigned SEL_BIT        = TDR_DATA_WIDTH;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_CAPTURE,
    OP_SHIFT
  } tdr_op_e;

  // Capture has priority over shift; nothing happens unless the TDR is selected.
  function automatic tdr_op_e decode_op(input logic sel, input logic ce, input logic se);
    tdr_op_e op;
    op = OP_IDLE;
    if (sel) begin
      if (ce)      op = OP_CAPTURE;
      else if (se) op = OP_SHIFT;
    end
    return op;
  endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_tdr_w3_ctl_if.sv
// IJTAG access bundle between the host network/mux and one gate1 TDR.
// The master is the host side; the slave is the TDR itself.
interface firebird7_in_gate1_tessent_tdr_w3_ctl_if #(
  parameter int unsigned DATA_WIDTH = 3
);

  logic                  ijtag_sel;
  logic                  ijtag_ce;
  logic                  ijtag_se;
  logic                  ijtag_ue;
  logic                  ijtag_si;
  logic                  ijtag_so;
  logic [DATA_WIDTH-1:0] capture_data_in;
  logic                  ijtag_select;
  logic [DATA_WIDTH-1:0] ijtag_data_out;

  modport master (
    output ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, capture_data_in,
    input  ijtag_so, ijtag_select, ijtag_data_out
  );

  modport slave (
    input  ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, capture_data_in,
    output ijtag_so, ijtag_select, ijtag_data_out
  );

endinterface

// File: rtl/firebird7_in_gate1_tessent_tdr_w3_ctl_shadow.sv
// Update (shadow) register for IJTAG TDRs: async reset, load on enable.
// Shared with the sibling TDRs in the gate1 instrument.
module firebird7_in_gate1_tdr_shadow #(
  parameter int unsigned          WIDTH       = 4,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] shadow_d;

  always_comb begin
    shadow_d = shadow_q;
    if (load_i) shadow_d = d_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) shadow_q <= RESET_VALUE;
    else     shadow_q <= shadow_d;
  end

  assign q_o = shadow_q;

endmodule

// File: rtl/firebird7_in_gate1_tessent_tdr_w3_ctl.sv
// IJTAG TDR driving the gate1 width-3 mux select/data and observing its output.
// Chain is {select, data}; scan-out is the chain LSB.
module firebird7_in_gate1_tessent_tdr_w3_ctl
  import firebird7_in_gate1_tdr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = TDR_DATA_WIDTH,
  parameter logic        RESET_SELECT = 1'b0
) (
  input  logic                                  ijtag_tck,
  input  logic                                  ijtag_reset,
  firebird7_in_gate1_tessent_tdr_w3_ctl_if.slave tdr
);

  localparam logic [DATA_WIDTH:0] SHADOW_RESET = {RESET_SELECT, {DATA_WIDTH{1'b0}}};

  logic [DATA_WIDTH:0] shift_q;
  logic [DATA_WIDTH:0] shift_d;
  logic [DATA_WIDTH:0] shadow_q;
  logic                update_en;

  always_comb begin
    shift_d = shift_q;
    unique case (decode_op(tdr.ijtag_sel, tdr.ijtag_ce, tdr.ijtag_se))
      OP_CAPTURE: shift_d = {shadow_q[DATA_WIDTH], tdr.capture_data_in};
      OP_SHIFT:   shift_d = {tdr.ijtag_si, shift_q[DATA_WIDTH:1]};
      default:    shift_d = shift_q;
    endcase
  end

  always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) shift_q <= '0;
    else             shift_q <= shift_d;
  end

  // Update loads the pre-edge chain, so it composes with a same-edge capture/shift.
  assign update_en = tdr.ijtag_sel & tdr.ijtag_ue;

  firebird7_in_gate1_tdr_shadow #(
    .WIDTH       (DATA_WIDTH + 1),
    .RESET_VALUE (SHADOW_RESET)
  ) u_shadow (
    .clk    (ijtag_tck),
    .rst    (ijtag_reset),
    .load_i (update_en),
    .d_i    (shift_q),
    .q_o    (shadow_q)
  );

  assign tdr.ijtag_so       = shift_q[0];
  assign tdr.ijtag_select   = shadow_q[DATA_WIDTH];
  assign tdr.ijtag_data_out = shadow_q[DATA_WIDTH-1:0];

endmodule

// File: doc/firebird7_in_gate1_tessent_tdr_w3_ctl.md
Name: firebird7_in_gate1_tessent_tdr_w3_ctl

Overview:
- IJTAG-side test data register (TDR) that drives the select and data inputs of the gate1 width-3 data mux, and observes the mux output.
- Provides capture/shift/update access from the IJTAG network.
  - Capture samples the mux output.
  - Shift moves bits serially between ijtag_si and ijtag_so.
  - Update loads the shadow register that drives the mux's ijtag_select and ijtag_data_in.
- Sits in firebird7_in_gate1_ijtag.instrument, one instance per mux.

Parameters:
- DATA_WIDTH, 3, width of the mux data path. The scan chain length is DATA_WIDTH+1.
- RESET_SELECT, 1'b0, value of the shadow select bit after reset. 0 means the functional path is selected.

Ports:
- ijtag_tck  input  1  test clock; all state updates on the rising edge.
- ijtag_reset  input  1  asynchronous, active-high reset.
- ijtag_sel  input  1  host SIB/SCB selects this TDR; gates ce/se/ue.
- ijtag_ce  input  1  capture enable.
- ijtag_se  input  1  shift enable.
- ijtag_ue  input  1  update enable.
- ijtag_si  input  1  scan-in.
- ijtag_so  output  1  scan-out.
- capture_data_in  input  DATA_WIDTH  observed mux data_out.
- ijtag_select  output  1  drives mux ijtag_select.
- ijtag_data_out  output  DATA_WIDTH  drives mux ijtag_data_in.

Behaviour:
- The block has two registers:
  - shift_reg[DATA_WIDTH:0]: bit DATA_WIDTH is the select slot; bits DATA_WIDTH-1:0 are the data slots.
  - shadow_reg[DATA_WIDTH:0], which drives the outputs.
- Output mapping:
  - ijtag_select = shadow_reg[DATA_WIDTH].
  - ijtag_data_out = shadow_reg[DATA_WIDTH-1:0].
  - ijtag_so = shift_reg[0], purely combinational from the register.
- Reset (asynchronous, on ijtag_reset=1):
  - shift_reg = 0.
  - shadow_reg = {RESET_SELECT, zeros}.
  - ijtag_so = 0, ijtag_select = RESET_SELECT, ijtag_data_out = 0.
  - Deassertion is synchronous to ijtag_tck; the codebase reset synchronizer upstream guarantees this.
- Reset mid-shift aborts the operation. No partial update may reach the shadow.
- Operation per rising edge, evaluated only when ijtag_sel=1; with ijtag_sel=0 every register holds.
  - CAPTURE (ce=1): shift_reg <= {shadow_reg[DATA_WIDTH], capture_data_in}. Readback shows the current select plus the observed data.
  - SHIFT (se=1 and ce=0): shift_reg <= {ijtag_si, shift_reg[DATA_WIDTH:1]}. LSB-first out, si enters at the MSB.
  - UPDATE (ue=1): shadow_reg <= shift_reg, using the pre-edge value of shift_reg.
- Simultaneous enables:
  - ce and se together: capture wins; the shift for that cycle is dropped.
  - ue with ce or se: update uses the old shift_reg, and shift_reg still captures or shifts in the same edge.
- Latency:
  - Outputs change 1 cycle after a ue edge.
  - ijtag_so reflects the new shift_reg 1 cycle after a capture or shift edge.
- Shift length: a full load is exactly DATA_WIDTH+1 shift cycles. Extra shifts keep rotating si in; no wrap-around or recirculation.
- ijtag_select and ijtag_data_out are glitch-free register outputs and hold indefinitely between updates.

Decomposition:
- Package firebird7_in_gate1_tdr_pkg contains:
  - typedef tdr_op_e {OP_IDLE, OP_CAPTURE, OP_SHIFT}.
  - Localparam SEL_BIT = DATA_WIDTH.
  - Function decode_op(sel, ce, se), which implements the priority above.
- Sub-module firebird7_in_gate1_tdr_shadow: a DATA_WIDTH+1 wide update register with async reset and load enable, reused by sibling TDRs.

Test Plan:
- Reset: assert ijtag_reset mid-shift with shift_reg=4'b1011 -> immediately so=0, ijtag_select=0, ijtag_data_out=3'b000. A following ue with no shifts keeps the outputs at 0.
- Load: sel=1, shift si bits 1,0,1,1 over 4 cycles with se=1 (LSB first, giving shift_reg=4'b1101), then ue=1 -> next cycle ijtag_select=1, ijtag_data_out=3'b101.
- Readback: after the load above, drive capture_data_in=3'b101, ce=1 for one cycle, then 4 shifts -> so sequence 1,0,1,1.
- Priority: ce=se=1 with capture_data_in=3'b010 and shadow select=0 -> shift_reg=4'b0010, no shift occurs. ue together with se -> shadow takes the pre-shift value.
- Deselect: sel=0 with se=1 and ue=1 for 10 cycles -> shift_reg, so, and all outputs unchanged.
- Overshift: shift 6 bits 0,0,1,1,1,0 then ue -> the shadow holds the last 4 bits shifted, so ijtag_select=0 and ijtag_data_out=3'b111.
